// File: rtl/ym3438_bus_master.sv
// ym3438_bus_master: turns one (port, register, value) write into the YM3438 CS/WR/RD pin sequence
module ym3438_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int ADDR_GAP   = 4,
    parameter int DATA_GAP   = 32,
    parameter int BUSY_POLL  = 1,
    parameter int POLL_MAX   = 64
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_port,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [1:0] ADDRESS,
    output logic [7:0] bus_data_o,
    output logic       bus_data_oe,
    input  logic [7:0] bus_data_i,
    output logic       done,
    output logic       timeout,
    output logic       active
);
    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, A_GAP,
        D_SETUP, D_STROBE, D_HOLD, POLL, POLL_GAP, WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, poll_q, poll_d;
    logic       port_q, port_d;
    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic       accept, last, timeout_d, addr_ph, data_ph;
    logic       unused_status;

    assign unused_status = ^bus_data_i[6:0];
    assign accept        = state_q == IDLE && cmd_valid;
    assign last          = cnt_q == 8'd0;
    assign port_d        = accept ? cmd_port : port_q;
    assign addr_d        = accept ? cmd_addr : addr_q;
    assign data_d        = accept ? cmd_data : data_q;

    function automatic logic [7:0] dur(state_t s);
        case (s)
            A_SETUP, D_SETUP:         dur = 8'(SETUP_CYC - 1);
            A_STROBE, D_STROBE, POLL: dur = 8'(STROBE_CYC - 1);
            A_HOLD, D_HOLD:           dur = 8'(HOLD_CYC - 1);
            A_GAP:                    dur = 8'(ADDR_GAP - 1);
            WAIT:                     dur = 8'(DATA_GAP - 1);
            default:                  dur = 8'd0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - 8'd1;
        poll_d    = poll_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE:     state_d = cmd_valid ? A_SETUP : IDLE;
            A_SETUP:  state_d = last ? A_STROBE : A_SETUP;
            A_STROBE: state_d = last ? A_HOLD : A_STROBE;
            A_HOLD:   state_d = last ? A_GAP : A_HOLD;
            A_GAP:    state_d = last ? D_SETUP : A_GAP;
            D_SETUP:  state_d = last ? D_STROBE : D_SETUP;
            D_STROBE: state_d = last ? D_HOLD : D_STROBE;
            D_HOLD: begin
                state_d = !last ? D_HOLD : BUSY_POLL != 0 ? POLL : WAIT;
                poll_d  = 8'd0;
            end
            POLL: if (last) begin
                if (!bus_data_i[7]) begin
                    state_d = IDLE;
                end else if (poll_q == 8'(POLL_MAX - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = POLL_GAP;
                    poll_d  = poll_q + 8'd1;
                end
            end
            POLL_GAP: state_d = POLL;
            WAIT:     state_d = last ? IDLE : WAIT;
            default:  state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = dur(state_d);
    end

    // pins are registered from the next state so they change on the same edge as the state
    assign addr_ph = state_d inside {A_SETUP, A_STROBE, A_HOLD};
    assign data_ph = state_d inside {D_SETUP, D_STROBE, D_HOLD};

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            poll_q      <= 8'd0;
            port_q      <= 1'b0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            CS          <= 1'b1;
            WR          <= 1'b1;
            RD          <= 1'b1;
            ADDRESS     <= 2'd0;
            bus_data_o  <= 8'd0;
            bus_data_oe <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            active      <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poll_q      <= poll_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            CS          <= !(addr_ph || data_ph || state_d == POLL);
            WR          <= !(state_d == A_STROBE || state_d == D_STROBE);
            RD          <= state_d != POLL;
            ADDRESS     <= addr_ph ? {port_d, 1'b0} : data_ph ? {port_d, 1'b1} : 2'd0;
            bus_data_o  <= addr_ph ? addr_d : data_ph ? data_d : 8'd0;
            bus_data_oe <= addr_ph || data_ph;
            done        <= state_q != IDLE && state_d == IDLE;
            timeout     <= timeout_d;
            active      <= state_d != IDLE;
            cmd_ready   <= state_d == IDLE;
        end
    end
endmodule

// File: tb/tb_ym3438_bus_master.sv
// tb_ym3438_bus_master: table-driven pin-sequence checks with a done/timeout scoreboard
module tb_ym3438_bus_master;
    logic clk = 1'b0, reset = 1'b1;
    logic valid_f = 1'b0, valid_p = 1'b0, cmd_port = 1'b0;
    logic [7:0] cmd_addr = 8'd0, cmd_data = 8'd0, status = 8'd0;
    logic rdy_f, cs_f, wr_f, rd_f, oe_f, done_f, to_f, act_f;
    logic rdy_p, cs_p, wr_p, rd_p, oe_p, done_p, to_p, act_p;
    logic [1:0] ad_f, ad_p;
    logic [7:0] bus_f, bus_p;
    int checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ym3438_bus_master #(.BUSY_POLL(0)) dut_f (
        .MCLK(clk), .reset(reset), .cmd_valid(valid_f), .cmd_ready(rdy_f),
        .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .CS(cs_f), .WR(wr_f), .RD(rd_f), .ADDRESS(ad_f), .bus_data_o(bus_f),
        .bus_data_oe(oe_f), .bus_data_i(status), .done(done_f), .timeout(to_f), .active(act_f));

    ym3438_bus_master #(.BUSY_POLL(1), .POLL_MAX(3)) dut_p (
        .MCLK(clk), .reset(reset), .cmd_valid(valid_p), .cmd_ready(rdy_p),
        .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .CS(cs_p), .WR(wr_p), .RD(rd_p), .ADDRESS(ad_p), .bus_data_o(bus_p),
        .bus_data_oe(oe_p), .bus_data_i(status), .done(done_p), .timeout(to_p), .active(act_p));

    typedef struct {
        bit sel; bit port; logic [7:0] addr; logic [7:0] data;
        int busy; int done; int reads; bit to;
    } vec_t;
    typedef struct { int at; bit to; } sb_t;
    sb_t q_f[$], q_p[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // {CS, WR, RD, oe, ready, active, ADDRESS, bus}
    function automatic logic [15:0] pins(input bit sel);
        return sel ? {cs_p, wr_p, rd_p, oe_p, rdy_p, act_p, ad_p, bus_p}
                   : {cs_f, wr_f, rd_f, oe_f, rdy_f, act_f, ad_f, bus_f};
    endfunction

    function automatic logic [15:0] exp_pins(input vec_t v, input int c, output logic [15:0] m);
        logic cs = 1'b1, wr = 1'b1, rd = 1'b1, oe = 1'b0, rdy = 1'b1, act = 1'b0;
        logic [1:0] ad = 2'd0;
        logic [7:0] b = 8'd0;
        m = 16'hFC00;
        if (c > 0 && c < v.done) begin
            rdy = 1'b0;
            act = 1'b1;
            if (c <= 8 || (c >= 13 && c <= 20)) begin
                cs = 1'b0;
                oe = 1'b1;
                ad = {v.port, 1'(c >= 13)};
                b  = c >= 13 ? v.data : v.addr;
                wr = !((c >= 3 && c <= 6) || (c >= 15 && c <= 18));
                m  = 16'hFFFF;
            end else if (c >= 21 && v.sel && (c - 21) % 5 < 4) begin
                cs = 1'b0;
                rd = 1'b0;
                m  = 16'hFF00;
            end
        end
        return {cs, wr, rd, oe, rdy, act, ad, b};
    endfunction

    task automatic sb_done(input bit sel, input logic d, input logic t);
        sb_t s;
        if (t && !d) check($sformatf("timeout without done sel%0d", sel), {31'd0, d}, 32'd1);
        if (d) begin
            if ((sel ? q_p.size() : q_f.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected done sel%0d: got done at cycle %0d want none", sel, cyc);
            end else begin
                s = sel ? q_p.pop_front() : q_f.pop_front();
                check($sformatf("done cycle sel%0d", sel), cyc, s.at);
                check($sformatf("timeout sel%0d", sel), {31'd0, t}, {31'd0, s.to});
            end
        end
    endtask

    always @(negedge clk) begin
        sb_done(1'b0, done_f, to_f);
        sb_done(1'b1, done_p, to_p);
    end

    task automatic run(input vec_t v, input bit hold, input vec_t nv);
        int base, rd_falls = 0, wr_falls = 0;
        logic [15:0] e, m, p;
        logic prd = 1'b1, pwr = 1'b1;
        sb_t s;
        base = cyc;
        cmd_port = v.port; cmd_addr = v.addr; cmd_data = v.data;
        valid_f = !v.sel; valid_p = v.sel;
        s.at = base + v.done;
        s.to = v.to;
        if (v.sel) q_p.push_back(s); else q_f.push_back(s);
        e = exp_pins(v, 0, m);
        check($sformatf("ready sel%0d c0", v.sel), {16'd0, pins(v.sel) & m}, {16'd0, e & m});
        for (int c = 1; c <= v.done; c++) begin
            @(negedge clk);
            e = exp_pins(v, c, m);
            p = pins(v.sel);
            check($sformatf("pins sel%0d addr%h c%0d", v.sel, v.addr, c), {16'd0, p & m}, {16'd0, e & m});
            if (!p[13] && prd) rd_falls++;
            if (!p[14] && pwr) wr_falls++;
            prd = p[13];
            pwr = p[14];
            status = (c >= 21 && (c - 21) / 5 < v.busy) ? 8'h80 : 8'h00;
            if (c == 1) begin
                if (hold) begin
                    cmd_port = nv.port; cmd_addr = nv.addr; cmd_data = nv.data;
                end else begin
                    valid_f = 1'b0; valid_p = 1'b0;
                    cmd_port = !v.port; cmd_addr = ~v.addr; cmd_data = ~v.data;
                end
            end
        end
        check($sformatf("rd pulses sel%0d addr%h", v.sel, v.addr), rd_falls, v.reads);
        check($sformatf("wr pulses sel%0d addr%h", v.sel, v.addr), wr_falls, 2);
        status = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t va, vb;
        logic [15:0] m, e;
        tbl[0] = '{0, 0, 8'h28, 8'hF0, 0, 53, 0, 0};
        tbl[1] = '{0, 1, 8'hA4, 8'h22, 0, 53, 0, 0};
        tbl[2] = '{1, 0, 8'h2B, 8'h80, 2, 35, 3, 0};
        tbl[3] = '{1, 1, 8'h30, 8'h71, 0, 25, 1, 0};
        tbl[4] = '{1, 0, 8'hB4, 8'hC0, 99, 35, 3, 1};
        tbl[5] = '{1, 1, 8'h40, 8'h1F, 1, 30, 2, 0};
        va = '{0, 0, 8'h28, 8'hF0, 0, 53, 0, 0};
        vb = '{0, 1, 8'h55, 8'hAA, 0, 53, 0, 0};

        repeat (3) @(negedge clk);
        check("reset f", {14'd0, pins(0), done_f, to_f}, {14'd0, 16'hE800, 2'b00});
        check("reset p", {14'd0, pins(1), done_p, to_p}, {14'd0, 16'hE800, 2'b00});
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i], 1'b0, tbl[i]);
            repeat (3) @(negedge clk);
        end

        run(va, 1'b1, vb);
        run(vb, 1'b0, vb);
        repeat (3) @(negedge clk);

        cmd_port = tbl[1].port; cmd_addr = tbl[1].addr; cmd_data = tbl[1].data;
        valid_f = 1'b1;
        check("ready before reset cmd", {31'd0, rdy_f}, 32'd1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            e = exp_pins(tbl[1], c, m);
            check($sformatf("pins pre-reset c%0d", c), {16'd0, pins(0) & m}, {16'd0, e & m});
            if (c == 1) valid_f = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid reset pins", {15'd0, pins(0) & 16'hFC00, done_f}, {15'd0, 16'hE800, 1'b0});
        reset = 1'b0;
        repeat (60) @(negedge clk);
        run(tbl[0], 1'b0, tbl[0]);
        repeat (3) @(negedge clk);

        check("scoreboard f empty", q_f.size(), 0);
        check("scoreboard p empty", q_p.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
